// File: rtl/shift_pkg.sv
// Shared constants and types for the shift arbiter slice: shift-type codes,
// default widths and the output-stage state encoding.
package shift_pkg;

  localparam int SHIFT_DATA_W = 32;
  localparam int SHIFT_AMT_W  = 5;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ASL = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } outState_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two shift requesters, the arbiter and the
// result consumer. The arbiter takes the slave view; the surroundings take master.
interface shift_arbiter_if import shift_pkg::*; #(
  parameter int DATA_W = SHIFT_DATA_W,
  parameter int AMT_W  = SHIFT_AMT_W
);

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [1:0]        req0_type;
  logic [AMT_W-1:0]  req0_amnt;
  logic              req0_en;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [1:0]        req1_type;
  logic [AMT_W-1:0]  req1_amnt;
  logic              req1_en;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_id;

  modport slave (
    input  req0_valid, req0_a, req0_type, req0_amnt, req0_en,
    output req0_ready,
    input  req1_valid, req1_a, req1_type, req1_amnt, req1_en,
    output req1_ready,
    input  rsp_ready,
    output rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req0_valid, req0_a, req0_type, req0_amnt, req0_en,
    input  req0_ready,
    output req1_valid, req1_a, req1_type, req1_amnt, req1_en,
    input  req1_ready,
    output rsp_ready,
    input  rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/shift_arbiter_shift_unit.sv
// Combinational barrel shifter shared by both requesters; en=0 passes the
// operand through untouched.
module shift_unit import shift_pkg::*; #(
  parameter int DATA_W = SHIFT_DATA_W,
  parameter int AMT_W  = SHIFT_AMT_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [1:0]        shType,
  input  logic [AMT_W-1:0]  amnt,
  input  logic              en,
  output logic [DATA_W-1:0] result
);

  // Shift selection by type; arithmetic left is the same as logical left
  always_comb begin
    result = a;
    if (en) begin
      case (shType)
        SH_LSL:  result = a << amnt;
        SH_LSR:  result = a >> amnt;
        SH_ASR:  result = DATA_W'($signed(a) >>> amnt);
        SH_ASL:  result = a << amnt;
        default: result = a;
      endcase
    end else begin
      result = a;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_unit between two requesters, with a
// single-entry registered result stage. Define SHIFT_ARB_STATS_EN for per-requester transfer counters.
module shift_arbiter import shift_pkg::*; #(
  parameter int DATA_W = SHIFT_DATA_W,
  parameter int AMT_W  = SHIFT_AMT_W
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SHIFT_ARB_STATS_EN
  input  logic                stat_clr,
  output logic [15:0]         stat0_cnt,
  output logic [15:0]         stat1_cnt,
`endif
  shift_arbiter_if.slave      bus
);

  outState_e         state_r;
  outState_e         stateNext_s;
  logic              lastGrant_r;
  logic [DATA_W-1:0] rspData_r;
  logic              rspId_r;

  logic              grantValid_s;
  logic              grantIdx_s;
  logic              canAccept_s;
  logic              transfer_s;

  logic [DATA_W-1:0] opA_s;
  logic [1:0]        opType_s;
  logic [AMT_W-1:0]  opAmnt_s;
  logic              opEn_s;
  logic [DATA_W-1:0] shifted_s;

  // Round-robin grant: on a tie the requester that did not win last time goes
  always_comb begin
    grantValid_s = 1'b0;
    grantIdx_s   = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grantValid_s = 1'b1;
      grantIdx_s   = ~lastGrant_r;
    end else if (bus.req0_valid) begin
      grantValid_s = 1'b1;
      grantIdx_s   = 1'b0;
    end else if (bus.req1_valid) begin
      grantValid_s = 1'b1;
      grantIdx_s   = 1'b1;
    end else begin
      grantValid_s = 1'b0;
      grantIdx_s   = 1'b0;
    end
  end

  // rst_n gates the readies so nothing is accepted while reset is held
  assign canAccept_s    = (state_r == ST_EMPTY) | bus.rsp_ready;
  assign transfer_s     = rst_n & grantValid_s & canAccept_s;
  assign bus.req0_ready = transfer_s & ~grantIdx_s;
  assign bus.req1_ready = transfer_s & grantIdx_s;

  // Operand mux feeding the single shared shifter
  always_comb begin
    opA_s    = bus.req0_a;
    opType_s = bus.req0_type;
    opAmnt_s = bus.req0_amnt;
    opEn_s   = bus.req0_en;
    if (grantIdx_s) begin
      opA_s    = bus.req1_a;
      opType_s = bus.req1_type;
      opAmnt_s = bus.req1_amnt;
      opEn_s   = bus.req1_en;
    end else begin
      opA_s    = bus.req0_a;
      opType_s = bus.req0_type;
      opAmnt_s = bus.req0_amnt;
      opEn_s   = bus.req0_en;
    end
  end

  shift_unit #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_shift (
    .a      (opA_s),
    .shType (opType_s),
    .amnt   (opAmnt_s),
    .en     (opEn_s),
    .result (shifted_s)
  );

  // Output-stage state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next state: a transfer always fills; a drain without refill empties
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (transfer_s) stateNext_s = ST_FULL;
        else            stateNext_s = ST_EMPTY;
      end
      ST_FULL: begin
        if (transfer_s)         stateNext_s = ST_FULL;
        else if (bus.rsp_ready) stateNext_s = ST_EMPTY;
        else                    stateNext_s = ST_FULL;
      end
      default: stateNext_s = ST_EMPTY;
    endcase
  end

  // Result register and grant history, loaded only on an accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspData_r   <= {DATA_W{1'b0}};
      rspId_r     <= 1'b0;
      lastGrant_r <= 1'b1;
    end else if (transfer_s) begin
      rspData_r   <= shifted_s;
      rspId_r     <= grantIdx_s;
      lastGrant_r <= grantIdx_s;
    end else begin
      rspData_r   <= rspData_r;
      rspId_r     <= rspId_r;
      lastGrant_r <= lastGrant_r;
    end
  end

  assign bus.rsp_valid = (state_r == ST_FULL);
  assign bus.rsp_data  = rspData_r;
  assign bus.rsp_id    = rspId_r;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] stat0Cnt_r;
  logic [15:0] stat1Cnt_r;

  // Saturating transfer counters; clear takes priority over a same-cycle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0Cnt_r <= 16'h0000;
      stat1Cnt_r <= 16'h0000;
    end else if (stat_clr) begin
      stat0Cnt_r <= 16'h0000;
      stat1Cnt_r <= 16'h0000;
    end else begin
      if (bus.req0_ready && (stat0Cnt_r != 16'hFFFF)) stat0Cnt_r <= stat0Cnt_r + 16'h0001;
      else                                            stat0Cnt_r <= stat0Cnt_r;
      if (bus.req1_ready && (stat1Cnt_r != 16'hFFFF)) stat1Cnt_r <= stat1Cnt_r + 16'h0001;
      else                                            stat1Cnt_r <= stat1Cnt_r;
    end
  end

  assign stat0_cnt = stat0Cnt_r;
  assign stat1_cnt = stat1Cnt_r;
`endif

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational barrel-shift datapath between two requesters: requester 0 is the execute-stage ALU path, requester 1 is the load/store byte-alignment path.
- Each requester uses a valid/ready handshake. Grants are round-robin.
- Results go into a single-entry registered output stage with its own valid/ready handshake.
- Output latency is 1 cycle; output stalls are handled.

Parameters:
- DATA_W, 32, operand/result width.
- AMT_W, 5, shift-amount width; must equal clog2(DATA_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  DATA_W  requester 0 operand.
- req0_type  in  2  requester 0 shift type.
- req0_amnt  in  AMT_W  requester 0 shift amount.
- req0_en  in  1  requester 0 shift enable (0 = pass-through).
- req1_valid, req1_ready, req1_a, req1_type, req1_amnt, req1_en: same as requester 0, for requester 1.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  DATA_W  shifted result.
- rsp_id  out  1  index of the requester that produced rsp_data.

Behaviour:
- Shift semantics:
  - 00 = logical left.
  - 01 = logical right.
  - 10 = arithmetic right (sign bit of a replicated).
  - 11 = arithmetic left, identical to logical left.
  - en=0 returns a unchanged regardless of type and amount.
  - The amount is taken modulo DATA_W by width; no overflow detection.
- Output stage is a 2-state FSM:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = !rsp_valid | rsp_ready.
- Grant rule:
  - One valid requester: it is granted.
  - Both valid: grant goes to the requester that is not last_grant.
  - None valid: no grant.
- Ready signals:
  - reqN_ready = can_accept & (grant==N). This is combinational from the valids and rsp_ready.
  - A requester must not make its valid depend on its ready.
- Transfer:
  - A transfer occurs when reqN_valid & reqN_ready.
  - At that clock edge: rsp_data <= shift(reqN operands), rsp_id <= N, rsp_valid <= 1, last_grant <= N.
- Drain:
  - rsp_valid & rsp_ready with no new transfer: rsp_valid <= 0. rsp_data and rsp_id hold their last values.
  - Drain and new transfer in the same cycle: the register is overwritten with no bubble, so there is one result per cycle of throughput.
- FULL with rsp_ready=0:
  - Both reqN_ready are 0.
  - rsp_data, rsp_id and rsp_valid hold stable.
  - last_grant does not change.
- Operands:
  - Sampled only on the transfer edge.
  - Operand changes while a requester is stalled are legal and are picked up on acceptance.
- Fairness: under continuous contention, grants alternate 0,1,0,1. Neither requester waits more than 1 accepted op.
- Reset:
  - Values: rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (requester 0 wins the first tie); both ready=0 while rst_n=0.
  - Asserting reset mid-operation discards a held result.
  - The first transfer is possible on the first rising edge after rst_n deasserts.

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- When defined:
  - Adds input stat_clr (1) and outputs stat0_cnt (16) and stat1_cnt (16).
  - Each counter increments on its requester's transfer and saturates at 16'hFFFF.
  - stat_clr synchronously zeroes both counters. stat_clr wins over a same-cycle increment.
  - Counters reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package shift_pkg holds:
  - Shift type constants SH_LSL=2'b00, SH_LSR=2'b01, SH_ASR=2'b10, SH_ASL=2'b11.
  - Default widths SHIFT_DATA_W=32 and SHIFT_AMT_W=5.
- Sub-module shift_unit:
  - Purely combinational: a, type, amnt, en -> out.
  - Instantiated once, fed from a grant-selected operand mux.
- Arbitration, FSM and the output register stay in shift_arbiter.

Test Plan:
- Basic ops, req0 only, rsp_ready=1:
  - a=0x8000_00F0, en=1.
  - type=10, amnt=4 -> rsp_data=0xF800_000F, rsp_id=0, one cycle after acceptance.
  - type=01, amnt=4 -> 0x0800_000F.
  - type=00, amnt=4 -> 0x0000_0F00.
  - type=11, amnt=4 -> 0x0000_0F00.
  - en=0 -> 0x8000_00F0.
- Tie after reset:
  - Both valid on the first cycle -> req0_ready=1, req1_ready=0.
  - Next cycle req1 is granted.
  - 8 back-to-back cycles give rsp_id sequence 0,1,0,1,0,1,0,1.
- Backpressure:
  - Result 0x1234 held, rsp_ready=0 for 3 cycles -> rsp_valid and rsp_data=0x1234 stable, both readies 0.
  - rsp_ready=1 with req1 valid -> drain and accept occur on the same edge.
- Reset while FULL: rst_n low while rsp_valid=1 -> rsp_valid=0, rsp_data=0 immediately, with no clock edge needed.
- Boundary amounts: a=0xFFFF_FFFF, type=01, amnt=31 -> 0x0000_0001; type=10, amnt=31 -> 0xFFFF_FFFF.
- SHIFT_ARB_STATS_EN:
  - 5 req0 ops and 3 req1 ops -> stat0_cnt=5, stat1_cnt=3.
  - stat_clr in the same cycle as a transfer -> both counters 0.
